// File: rtl/axi3_slave_mem.sv
// axi3_slave_mem: AXI3 slave backed by a MEM_DEPTH x 32-bit word memory
// Ports: clock, aresetn (async active-low); AW/W/B write channels and AR/R read
// channels, one outstanding burst per direction, FIXED/INCR/WRAP, byte strobes.
module axi3_slave_mem #(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clock,
  input  logic        aresetn,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [1:0] W_ADDR = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [0:0] R_ADDR = 1'b0, R_DATA = 1'b1;
  function automatic logic wrap_ok(input logic [7:0] len);
    return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
  endfunction
  // Invalid WRAP lengths fall through to INCR stepping
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] inc, m;
    inc = 32'd1 << size;
    m = (({24'd0, len} + 32'd1) << size) - 32'd1;
    return burst == 2'b00 ? a : (burst == 2'b10 && wrap_ok(len)) ? ((a & ~m) | ((a + inc) & m)) : a + inc;
  endfunction
  function automatic logic in_range(input logic [31:0] a);
    return a >= BASE_ADDR && ((a - BASE_ADDR) >> 2) < 32'(MEM_DEPTH);
  endfunction
  function automatic logic [IW-1:0] idx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction
  logic [31:0] mem [MEM_DEPTH];
  logic [1:0]  wstate;
  logic [3:0]  wid_q;
  logic [31:0] waddr;
  logic [7:0]  wlen, wbeat;
  logic [2:0]  wsize;
  logic [1:0]  wburst;
  logic        werr, wdrop, wfire, wend, wok, wbeat_err;
  always_comb begin
    wfire = wvalid && wready;
    wend = wlast || wbeat == wlen;
    wok = !wdrop && in_range(waddr);
    wbeat_err = !in_range(waddr) || wid != wid_q || (wlast != (wbeat == wlen));
  end
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      wstate <= W_ADDR;
      awready <= 1'b0;
      wready <= 1'b0;
      bvalid <= 1'b0;
      bid <= 4'd0;
      bresp <= 2'b00;
      wid_q <= 4'd0;
      waddr <= 32'd0;
      wlen <= 8'd0;
      wbeat <= 8'd0;
      wsize <= 3'd0;
      wburst <= 2'b00;
      werr <= 1'b0;
      wdrop <= 1'b0;
    end else begin
      case (wstate)
        W_ADDR: if (awvalid && awready) begin
          awready <= 1'b0;
          wready <= 1'b1;
          wid_q <= awid;
          waddr <= awaddr;
          wlen <= awlen;
          wsize <= awsize;
          wburst <= awburst;
          wbeat <= 8'd0;
          wdrop <= awsize > 3'd2 || awburst == 2'b11;
          werr <= awsize > 3'd2 || awburst == 2'b11 || (awburst == 2'b10 && !wrap_ok(awlen));
          wstate <= W_DATA;
        end else awready <= 1'b1;
        W_DATA: if (wfire) begin
          waddr <= next_addr(waddr, wlen, wsize, wburst);
          wbeat <= wbeat + 8'd1;
          werr <= werr || wbeat_err;
          if (wend) begin
            wready <= 1'b0;
            bvalid <= 1'b1;
            bid <= wid_q;
            bresp <= (werr || wbeat_err) ? 2'b10 : 2'b00;
            wstate <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          bvalid <= 1'b0;
          awready <= 1'b1;
          wstate <= W_ADDR;
        end
        default: wstate <= W_ADDR;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (wfire && wok)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[idx(waddr)][8*i +: 8] <= wdata[8*i +: 8];
  end
  logic [0:0]  rstate;
  logic [31:0] raddr, fa, fnext, fdata;
  logic [7:0]  rlen, rbeat;
  logic [2:0]  rsize;
  logic [1:0]  rburst;
  logic        rbad, fbad, fok;
  // Fetch address is the AR request while idle, the stored next address mid-burst
  always_comb begin
    fa = rstate == R_ADDR ? araddr : raddr;
    fbad = rstate == R_ADDR ? (arsize > 3'd2 || arburst == 2'b11) : rbad;
    fok = !fbad && in_range(fa);
    fdata = fok ? mem[idx(fa)] : 32'd0;
    fnext = rstate == R_ADDR ? next_addr(araddr, arlen, arsize, arburst) : next_addr(raddr, rlen, rsize, rburst);
  end
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      rstate <= R_ADDR;
      arready <= 1'b0;
      rvalid <= 1'b0;
      rid <= 4'd0;
      rdata <= 32'd0;
      rresp <= 2'b00;
      rlast <= 1'b0;
      raddr <= 32'd0;
      rlen <= 8'd0;
      rbeat <= 8'd0;
      rsize <= 3'd0;
      rburst <= 2'b00;
      rbad <= 1'b0;
    end else begin
      case (rstate)
        R_ADDR: if (arvalid && arready) begin
          arready <= 1'b0;
          rvalid <= 1'b1;
          rid <= arid;
          rdata <= fdata;
          rresp <= fok ? 2'b00 : 2'b10;
          rlast <= arlen == 8'd0;
          raddr <= fnext;
          rlen <= arlen;
          rsize <= arsize;
          rburst <= arburst;
          rbad <= fbad;
          rbeat <= 8'd0;
          rstate <= R_DATA;
        end else arready <= 1'b1;
        R_DATA: if (rvalid && rready) begin
          if (rlast) begin
            rvalid <= 1'b0;
            rlast <= 1'b0;
            arready <= 1'b1;
            rstate <= R_ADDR;
          end else begin
            rdata <= fdata;
            rresp <= fok ? 2'b00 : 2'b10;
            rlast <= rbeat + 8'd1 == rlen;
            raddr <= fnext;
            rbeat <= rbeat + 8'd1;
          end
        end
        default: rstate <= R_ADDR;
      endcase
    end
  end
endmodule

// File: tb/tb_axi3_slave_mem.sv
// tb_axi3_slave_mem: directed self-checking bench for axi3_slave_mem
module tb_axi3_slave_mem;
  logic        clock = 1'b0, aresetn = 1'b0;
  logic [3:0]  awid = 0, wid = 0, arid = 0, bid, rid;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [7:0]  awlen = 0, arlen = 0;
  logic [2:0]  awsize = 0, arsize = 0;
  logic [1:0]  awburst = 0, arburst = 0, bresp, rresp;
  logic [3:0]  wstrb = 0;
  logic        awvalid = 0, wlast = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [31:0] wd [4];
  logic [31:0] ed [4];
  logic [1:0]  er [4];
  int checks = 0, errors = 0;
  axi3_slave_mem dut (
    .clock(clock), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [3:0] id, input logic [3:0] did, input logic [31:0] addr,
                    input logic [7:0] len, input logic [3:0] strb, input logic [1:0] eresp);
    int k;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    k = 0;
    while (!awready && k < 20) begin tick; k++; end
    chk("aw_wait", 32'(k < 20), 1);
    tick;
    awvalid = 1'b0;
    chk("wready_after_aw", 32'(wready), 1);
    for (int i = 0; i <= int'(len); i++) begin
      wid = did; wdata = wd[i]; wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
      k = 0;
      while (!wready && k < 20) begin tick; k++; end
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_after_wlast", 32'(bvalid), 1);
    chk("bid", 32'(bid), 32'(id));
    chk("bresp", 32'(bresp), 32'(eresp));
    bready = 1'b1;
    tick;
    bready = 1'b0;
    chk("bvalid_cleared", 32'(bvalid), 0);
    chk("awready_after_b", 32'(awready), 1);
  endtask
  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input int stall);
    int k, i;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    k = 0;
    while (!arready && k < 20) begin tick; k++; end
    chk("ar_wait", 32'(k < 20), 1);
    tick;
    arvalid = 1'b0;
    chk("arready_low", 32'(arready), 0);
    rready = 1'b1;
    i = 0; k = 0;
    while (i <= int'(len) && k < 40) begin
      if (rvalid) begin
        if (i == stall) begin
          rready = 1'b0;
          repeat (3) begin
            tick;
            chk("stall_rvalid", 32'(rvalid), 1);
            chk("stall_rdata", rdata, ed[i]);
            chk("stall_rlast", 32'(rlast), 32'(i == int'(len)));
          end
          rready = 1'b1;
        end
        chk("rdata", rdata, ed[i]);
        chk("rresp", 32'(rresp), 32'(er[i]));
        chk("rid", 32'(rid), 32'(id));
        chk("rlast", 32'(rlast), 32'(i == int'(len)));
        i++;
      end
      tick;
      k++;
    end
    chk("r_done", 32'(k < 40), 1);
    rready = 1'b0;
    chk("rvalid_after_last", 32'(rvalid), 0);
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    aresetn = 1'b1;
    tick;
    chk("awready_after_rst", 32'(awready), 1);
    chk("arready_after_rst", 32'(arready), 1);
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    wr(4'd5, 4'd5, 32'h10, 8'd3, 4'hF, 2'b00);
    ed[0] = 32'hA0; ed[1] = 32'hA1; ed[2] = 32'hA2; ed[3] = 32'hA3;
    er[0] = 0; er[1] = 0; er[2] = 0; er[3] = 0;
    rd(4'd9, 32'h10, 8'd3, 2'b01, 1);
    wd[0] = 1; wd[1] = 2; wd[2] = 3; wd[3] = 4;
    wr(4'd1, 4'd1, 32'h10, 8'd3, 4'hF, 2'b00);
    ed[0] = 3; ed[1] = 4; ed[2] = 1; ed[3] = 2;
    rd(4'd2, 32'h18, 8'd3, 2'b10, -1);
    wd[0] = 32'hFFFFFFFF;
    wr(4'd3, 4'd3, 32'h20, 8'd0, 4'hF, 2'b00);
    wd[0] = 32'h11223344;
    wr(4'd3, 4'd3, 32'h20, 8'd0, 4'b0101, 2'b00);
    ed[0] = 32'hFF22FF44;
    rd(4'd4, 32'h20, 8'd0, 2'b01, -1);
    wd[0] = 32'hDEADBEEF; wd[1] = 32'h12345678;
    wr(4'd6, 4'd6, 32'hFFC, 8'd1, 4'hF, 2'b10);
    ed[0] = 32'hDEADBEEF; ed[1] = 0; er[0] = 2'b00; er[1] = 2'b10;
    rd(4'd7, 32'hFFC, 8'd1, 2'b01, -1);
    wd[0] = 32'h55;
    wr(4'd2, 4'd7, 32'h30, 8'd0, 4'hF, 2'b10);
    ed[0] = 0; er[0] = 2'b10;
    rd(4'd8, 32'h10, 8'd0, 2'b11, -1);
    arid = 4'd3; araddr = 32'h10; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    rready = 1'b1;
    chk("pre_rst_rvalid", 32'(rvalid), 1);
    tick;
    chk("beat2_rdata", rdata, 2);
    aresetn = 1'b0;
    #1;
    rready = 1'b0;
    chk("async_rst_rvalid", 32'(rvalid), 0);
    chk("async_rst_arready", 32'(arready), 0);
    tick;
    aresetn = 1'b1;
    tick;
    chk("arready_after_release", 32'(arready), 1);
    chk("rvalid_after_release", 32'(rvalid), 0);
    ed[0] = 1; ed[1] = 2; ed[2] = 3; ed[3] = 4;
    er[0] = 0; er[1] = 0; er[2] = 0; er[3] = 0;
    rd(4'd10, 32'h10, 8'd3, 2'b01, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
